// File: rtl/uncached_loader.sv
// Uncached load path: one single-beat AXI read per MEM-stage load.
// Arbitrates for the shared port, then returns the extended load data.
module uncached_loader (
  input  logic        clk,
  input  logic        rst_n,
  output logic        uncached_loader_req,
  input  logic        uncached_loader_grnt,
  output logic [3:0]  uncached_loader_arid,
  output logic [31:0] uncached_loader_araddr,
  output logic [3:0]  uncached_loader_arlen,
  output logic [2:0]  uncached_loader_arsize,
  output logic [1:0]  uncached_loader_arburst,
  output logic [1:0]  uncached_loader_arlock,
  output logic [3:0]  uncached_loader_arcache,
  output logic [2:0]  uncached_loader_arprot,
  output logic        uncached_loader_arvalid,
  input  logic        uncached_loader_arready,
  input  logic [3:0]  uncached_loader_rid,
  input  logic [31:0] uncached_loader_rdata,
  input  logic [1:0]  uncached_loader_rresp,
  input  logic        uncached_loader_rlast,
  input  logic        uncached_loader_rvalid,
  output logic        uncached_loader_rready,
  input  logic        uncached_loader_cpu_uncached,
  input  logic        uncached_loader_cpu_re,
  input  logic [31:0] uncached_loader_cpu_addr,
  input  logic [2:0]  uncached_loader_cpu_load_type,
  output logic [31:0] uncached_loader_cpu_rdata,
  output logic        uncached_loader_cpu_Stall,
  output logic        uncached_loader_cpu_PC_Stall
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [3:0] RD_ID = 4'b0011;

  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  logic [2:0]  state_q, state_d;
  logic        req_q, req_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  type_q, type_d;

  logic need_read;
  logic beat_ok;
  logic unused_resp;

  assign need_read = uncached_loader_cpu_uncached
                   & uncached_loader_cpu_re;

  assign beat_ok = uncached_loader_rvalid
                 & rready_q
                 & (uncached_loader_rid == RD_ID);

  // Response status and last flag carry no information for one beat.
  assign unused_resp = ^{uncached_loader_rresp, uncached_loader_rlast};

  function automatic logic [31:0] extend(
    input logic [2:0]  t,
    input logic [1:0]  off,
    input logic [31:0] d
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    unique case (off)
      2'd0: b = d[7:0];
      2'd1: b = d[15:8];
      2'd2: b = d[23:16];
      2'd3: b = d[31:24];
      default: b = d[7:0];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (t)
      LT_LB:   r = {{24{b[7]}}, b};
      LT_LBU:  r = {24'd0, b};
      LT_LH:   r = {{16{h[15]}}, h};
      LT_LHU:  r = {16'd0, h};
      default: r = d;
    endcase
    return r;
  endfunction

  // Next-state and registered-output logic for the read transaction.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    type_d    = type_q;
    unique case (state_q)
      S_IDLE: begin
        req_d     = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        if (need_read) begin
          addr_d  = uncached_loader_cpu_addr;
          type_d  = uncached_loader_cpu_load_type;
          req_d   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (uncached_loader_grnt) begin
          arvalid_d = 1'b1;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (uncached_loader_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (beat_ok) begin
          rdata_d  = extend(type_q, addr_q[1:0],
                            uncached_loader_rdata);
          rready_d = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        req_d     = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rdata_q   <= 32'd0;
      addr_q    <= 32'd0;
      type_q    <= 3'd0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      type_q    <= type_d;
    end
  end

  // Stall covers the request cycle and every wait state, not DONE.
  always_comb begin
    uncached_loader_cpu_Stall = 1'b0;
    if (state_q == S_IDLE)
      uncached_loader_cpu_Stall = need_read;
    else if (state_q == S_WAIT || state_q == S_ADDR ||
             state_q == S_DATA)
      uncached_loader_cpu_Stall = 1'b1;
  end

  assign uncached_loader_cpu_PC_Stall = uncached_loader_cpu_Stall;

  assign uncached_loader_req       = req_q;
  assign uncached_loader_arvalid   = arvalid_q;
  assign uncached_loader_rready    = rready_q;
  assign uncached_loader_cpu_rdata = rdata_q;
  assign uncached_loader_araddr    = {addr_q[31:2], 2'b00};

  assign uncached_loader_arid    = RD_ID;
  assign uncached_loader_arlen   = 4'd0;
  assign uncached_loader_arsize  = 3'b010;
  assign uncached_loader_arburst = 2'd0;
  assign uncached_loader_arlock  = 2'd0;
  assign uncached_loader_arcache = 4'd0;
  assign uncached_loader_arprot  = 3'd0;

endmodule

// File: tb/tb_uncached_loader.sv
// Bench for uncached_loader: randomized loads against a load model.
// Bus responder delays are chosen per transaction.
module tb_uncached_loader;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        grnt;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        cpu_uncached;
  logic        cpu_re;
  logic [31:0] cpu_addr;
  logic [2:0]  cpu_type;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        pc_stall;

  int checks = 0;
  int errors = 0;

  uncached_loader dut (
    .clk                           (clk),
    .rst_n                         (rst_n),
    .uncached_loader_req           (req),
    .uncached_loader_grnt          (grnt),
    .uncached_loader_arid          (arid),
    .uncached_loader_araddr        (araddr),
    .uncached_loader_arlen         (arlen),
    .uncached_loader_arsize        (arsize),
    .uncached_loader_arburst       (arburst),
    .uncached_loader_arlock        (arlock),
    .uncached_loader_arcache       (arcache),
    .uncached_loader_arprot        (arprot),
    .uncached_loader_arvalid       (arvalid),
    .uncached_loader_arready       (arready),
    .uncached_loader_rid           (rid),
    .uncached_loader_rdata         (rdata),
    .uncached_loader_rresp         (rresp),
    .uncached_loader_rlast         (rlast),
    .uncached_loader_rvalid        (rvalid),
    .uncached_loader_rready        (rready),
    .uncached_loader_cpu_uncached  (cpu_uncached),
    .uncached_loader_cpu_re        (cpu_re),
    .uncached_loader_cpu_addr      (cpu_addr),
    .uncached_loader_cpu_load_type (cpu_type),
    .uncached_loader_cpu_rdata     (cpu_rdata),
    .uncached_loader_cpu_Stall     (stall),
    .uncached_loader_cpu_PC_Stall  (pc_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: pick the addressed lane, then sign- or zero-extend.
  function automatic logic [31:0] ref_load(
    input logic [2:0]  t,
    input logic [31:0] a,
    input logic [31:0] d
  );
    logic [31:0] sh;
    logic [31:0] res;
    int          boff;
    boff = int'(a[1:0]);
    if (t == 3'b001 || t == 3'b010) begin
      sh = d >> (8 * boff);
      res = sh & 32'hFF;
      if (t == 3'b001 && sh[7]) res = res | 32'hFFFF_FF00;
    end else if (t == 3'b011 || t == 3'b100) begin
      sh = d >> (a[1] ? 16 : 0);
      res = sh & 32'hFFFF;
      if (t == 3'b011 && sh[15]) res = res | 32'hFFFF_0000;
    end else begin
      res = d;
    end
    return res;
  endfunction

  // Drives one load with a delayed responder and records what happened.
  // junk = number of beats offered with a foreign ID before the real one.
  task automatic run_txn(
    input  logic [31:0] a,
    input  logic [2:0]  t,
    input  logic [31:0] d,
    input  int          dg,
    input  int          da,
    input  int          dr,
    input  int          junk,
    output int          done_cyc,
    output logic [31:0] res,
    output logic [31:0] araddr_s,
    output int          stall_cnt,
    output int          arv_cnt,
    output int          rr_cnt,
    output int          req_cnt,
    output bit          arv_drop,
    output bit          early,
    output bit          after_ok
  );
    int          cyc;
    bit          hs;
    bit          prev_av;
    logic [31:0] r0;
    cyc = 0; hs = 0; prev_av = 0;
    done_cyc = -1; res = 'x; araddr_s = 'x;
    stall_cnt = 0; arv_cnt = 0; rr_cnt = 0; req_cnt = 0;
    arv_drop = 0; early = 0;
    @(negedge clk);
    r0 = cpu_rdata;
    cpu_uncached = 1'b1;
    cpu_re = 1'b1;
    cpu_addr = a;
    cpu_type = t;
    while (done_cyc < 0 && cyc < 200) begin
      if (cyc > 0) begin
        cpu_addr = $urandom;
        cpu_type = 3'($urandom);
      end
      if (req) req_cnt++;
      if (arvalid) arv_cnt++;
      if (rready) rr_cnt++;
      if (prev_av && !arvalid && !hs) arv_drop = 1;
      grnt    = req && (req_cnt > dg);
      arready = arvalid && (arv_cnt > da);
      rvalid  = rready && (rr_cnt > dr);
      rid     = (rr_cnt - dr - 1 < junk) ? 4'd2 : 4'd3;
      rdata   = (rid == 4'd2) ? 32'hDEAD_BEEF : d;
      #1;
      if (stall) stall_cnt++;
      if (arvalid) araddr_s = araddr;
      if (req && !stall) begin
        done_cyc = cyc;
        res = cpu_rdata;
      end else if (cpu_rdata !== r0) begin
        early = 1;
      end
      hs = hs | (arvalid & arready);
      prev_av = arvalid;
      cyc++;
      @(negedge clk);
    end
    grnt = 0; arready = 0; rvalid = 0;
    cpu_re = 1'b0;
    #1;
    after_ok = !req && !stall && !arvalid && !rready;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    grnt = 0; arready = 0; rvalid = 0;
    rid = 0; rdata = 0; rresp = 0; rlast = 1;
    cpu_uncached = 0; cpu_re = 0;
    cpu_addr = 0; cpu_type = 0;
    #12;
    checks++;
    if ({req, arvalid, rready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl got %b want 000",
               {req, arvalid, rready});
    end
    checks++;
    if (cpu_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_rdata got %h want 0", cpu_rdata);
    end
    checks++;
    if ({stall, pc_stall} !== 2'b00) begin
      errors++;
      $display("FAIL reset_stall got %b want 00",
               {stall, pc_stall});
    end
    checks++;
    if ({arid, arlen, arsize, arburst, arlock, arcache, arprot}
        !== {4'd3, 4'd0, 3'd2, 2'd0, 2'd0, 4'd0, 3'd0}) begin
      errors++;
      $display("FAIL ar_consts got id=%h len=%h size=%h",
               arid, arlen, arsize);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lw_basic;
    int done, sc, ac, rc, qc;
    logic [31:0] res, aa;
    bit drop, early, after;
    run_txn(32'h1FAF_F004, 3'b000, 32'h1234_5678, 0, 0, 0, 0,
            done, res, aa, sc, ac, rc, qc, drop, early, after);
    checks++;
    if (done !== 4) begin
      errors++;
      $display("FAIL lw_done_cycle got %0d want 4", done);
    end
    checks++;
    if (res !== 32'h1234_5678) begin
      errors++;
      $display("FAIL lw_data got %h want 12345678", res);
    end
    checks++;
    if (aa !== 32'h1FAF_F004) begin
      errors++;
      $display("FAIL lw_araddr got %h want 1faff004", aa);
    end
    checks++;
    if (sc !== 4 || qc !== 4) begin
      errors++;
      $display("FAIL lw_stall_req got stall=%0d req=%0d want 4/4",
               sc, qc);
    end
    checks++;
    if (!after || early) begin
      errors++;
      $display("FAIL lw_after got idle=%0d early=%0d want 1/0",
               after, early);
    end
  endtask

  task automatic test_extend;
    logic [31:0] ta [4];
    logic [2:0]  tt [4];
    logic [31:0] tw [4];
    int done, sc, ac, rc, qc;
    logic [31:0] res, aa, a, d, exp;
    logic [2:0] t;
    bit drop, early, after;
    ta[0] = 32'h0000_1003; tt[0] = 3'b001; tw[0] = 32'hFFFF_FF80;
    ta[1] = 32'h0000_1003; tt[1] = 3'b010; tw[1] = 32'h0000_0080;
    ta[2] = 32'h0000_1002; tt[2] = 3'b011; tw[2] = 32'hFFFF_80FF;
    ta[3] = 32'h0000_1002; tt[3] = 3'b100; tw[3] = 32'h0000_80FF;
    for (int i = 0; i < 4; i++) begin
      run_txn(ta[i], tt[i], 32'h80FF_FFFF, 0, 0, 0, 0,
              done, res, aa, sc, ac, rc, qc, drop, early, after);
      checks++;
      if (res !== tw[i]) begin
        errors++;
        $display("FAIL ext_plan%0d got %h want %h", i, res, tw[i]);
      end
    end
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      d = $urandom;
      t = 3'($urandom_range(7, 0));
      exp = ref_load(t, a, d);
      run_txn(a, t, d, 0, 0, 0, 0,
              done, res, aa, sc, ac, rc, qc, drop, early, after);
      checks++;
      if (res !== exp || aa !== {a[31:2], 2'b00}) begin
        errors++;
        $display("FAIL ext_rand t=%0d a=%h got %h/%h want %h/%h",
                 t, a, res, aa, exp, {a[31:2], 2'b00});
      end
    end
  endtask

  task automatic test_delays;
    int done, sc, ac, rc, qc, dg, da, dr;
    logic [31:0] res, aa, a, d;
    bit drop, early, after;
    run_txn(32'h0000_2000, 3'b000, 32'hA5A5_0F0F, 3, 2, 4, 0,
            done, res, aa, sc, ac, rc, qc, drop, early, after);
    checks++;
    if (done !== 13 || qc !== 13 || sc !== 13) begin
      errors++;
      $display("FAIL delay_plan got done=%0d req=%0d stall=%0d want 13",
               done, qc, sc);
    end
    checks++;
    if (ac !== 3 || drop || rc !== 5 || res !== 32'hA5A5_0F0F) begin
      errors++;
      $display("FAIL delay_hold got arv=%0d drop=%0d rr=%0d d=%h want 3/0/5/a5a50f0f",
               ac, drop, rc, res);
    end
    for (int i = 0; i < 12; i++) begin
      dg = $urandom_range(4, 0);
      da = $urandom_range(4, 0);
      dr = $urandom_range(4, 0);
      a = $urandom;
      d = $urandom;
      run_txn(a, 3'b000, d, dg, da, dr, 0,
              done, res, aa, sc, ac, rc, qc, drop, early, after);
      checks++;
      if (done !== 4 + dg + da + dr || ac !== da + 1 ||
          rc !== dr + 1 || drop || res !== d || !after) begin
        errors++;
        $display("FAIL delay_rand %0d/%0d/%0d got done=%0d arv=%0d rr=%0d want %0d/%0d/%0d",
                 dg, da, dr, done, ac, rc,
                 4 + dg + da + dr, da + 1, dr + 1);
      end
    end
  endtask

  task automatic test_rid_filter;
    int done, sc, ac, rc, qc;
    logic [31:0] res, aa;
    bit drop, early, after;
    run_txn(32'h0000_3000, 3'b000, 32'h0000_0001, 0, 0, 0, 1,
            done, res, aa, sc, ac, rc, qc, drop, early, after);
    checks++;
    if (done !== 5 || res !== 32'h0000_0001) begin
      errors++;
      $display("FAIL rid_filter got done=%0d d=%h want 5/00000001",
               done, res);
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL rid_early got changed=1 want 0");
    end
  endtask

  task automatic test_reset_in_addr;
    int n;
    n = 0;
    @(negedge clk);
    cpu_uncached = 1; cpu_re = 1;
    cpu_addr = 32'h0000_4008; cpu_type = 3'b000;
    grnt = 1; arready = 0;
    while (!arvalid && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!arvalid) begin
      errors++;
      $display("FAIL rst_addr_reach got arvalid=0 want 1");
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req, arvalid, rready} !== 3'b000 || cpu_rdata !== 0) begin
      errors++;
      $display("FAIL rst_async got ctl=%b d=%h want 000/0",
               {req, arvalid, rready}, cpu_rdata);
    end
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_stall_need got %b want 1", stall);
    end
    cpu_re = 0;
    grnt = 0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_stall_idle got %b want 0", stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({req, arvalid, rready} !== 3'b000) begin
      errors++;
      $display("FAIL rst_after got %b want 000",
               {req, arvalid, rready});
    end
  endtask

  task automatic test_no_req;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cpu_uncached = (k == 1);
      cpu_re = (k == 0);
      cpu_addr = $urandom;
      grnt = 1; arready = 1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        #1;
        checks++;
        if (req !== 0 || stall !== 0 || arvalid !== 0) begin
          errors++;
          $display("FAIL no_req%0d got req=%b stall=%b arv=%b want 0",
                   k, req, stall, arvalid);
        end
      end
    end
    cpu_uncached = 0; cpu_re = 0;
    grnt = 0; arready = 0;
  endtask

  task automatic test_back_to_back;
    int done, sc, ac, rc, qc;
    logic [31:0] res, aa, a, d;
    logic [2:0] t;
    bit drop, early, after;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      d = $urandom;
      t = 3'($urandom_range(4, 0));
      run_txn(a, t, d, i % 2, 0, i % 3, i % 2,
              done, res, aa, sc, ac, rc, qc, drop, early, after);
      checks++;
      if (res !== ref_load(t, a, d) ||
          done !== 4 + (i % 2) + (i % 3) + (i % 2)) begin
        errors++;
        $display("FAIL b2b%0d got %h done=%0d want %h", i, res, done,
                 ref_load(t, a, d));
      end
    end
  endtask

  initial begin
    test_reset;
    test_lw_basic;
    test_extend;
    test_delays;
    test_rid_filter;
    test_reset_in_addr;
    test_no_req;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
